// File: rtl/me_control_param.sv
// Full-search block-matching motion estimator control unit (BLK PEs, start/busy/done).
// Optional `ME_CTRL_HOLD_EN adds a hold input that freezes the RUN sequence.
module me_control_param #(
   parameter  int BLK = 16,
   localparam int LB  = $clog2(BLK),
   localparam int CW  = 3*LB + 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
`ifdef ME_CTRL_HOLD_EN
   input  logic            hold,
`endif
   output logic [BLK-1:0]  S1S2mux,
   output logic [BLK-1:0]  newDist,
   output logic [BLK-1:0]  PEready,
   output logic            CompStart,
   output logic [LB-1:0]   VectorX,
   output logic [LB-1:0]   VectorY,
   output logic [2*LB-1:0] AddressR,
   output logic [2*LB+1:0] AddressS1,
   output logic [2*LB+1:0] AddressS2,
   output logic            busy,
   output logic            done
);

   localparam int RUNLEN = BLK**3 + BLK;
   localparam logic [LB-1:0] XMAX = LB'(BLK-1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t state, nextState;
   logic [CW-1:0] cnt, cntNext;
   logic holdI;

`ifdef ME_CTRL_HOLD_EN
   assign holdI = hold;
`else
   assign holdI = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= nextState;
         cnt   <= cntNext;
      end
   end

   always_comb begin
      nextState = state;
      cntNext   = '0;
      unique case (state)
         IDLE: if (start) nextState = RUN;
         RUN: begin
            cntNext = cnt;
            if (!holdI) begin
               if (cnt == CW'(RUNLEN-1)) nextState = FIN;
               else cntNext = cnt + CW'(1);
            end
         end
         FIN:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   logic            run, strobeEn, inBlk, inCmp, loHit, peHit;
   logic [LB-1:0]   x, y, v;
   logic [2*LB-1:0] lo;
   logic [LB:0]     sumVY, vyFull;
   logic [BLK-1:0]  oneHot;

   assign run      = (state == RUN);
   assign strobeEn = run && !holdI;
   assign x        = cnt[LB-1:0];
   assign y        = cnt[2*LB-1:LB];
   assign v        = cnt[3*LB-1:2*LB];
   assign lo       = cnt[2*LB-1:0];
   // cnt never reaches 2*BLK^3, so the top bit alone marks the flush tail
   assign inBlk    = run && !cnt[3*LB];
   assign inCmp    = run && (cnt[CW-1:2*LB] != '0);
   assign loHit    = (lo[2*LB-1:LB] == '0);
   assign peHit    = inCmp && loHit;
   assign sumVY    = {1'b0, v} + {1'b0, y};
   assign vyFull   = cnt[CW-1:2*LB] - (LB+1)'(1);
   assign oneHot   = BLK'(1) << lo[LB-1:0];

   always_comb begin
      S1S2mux   = '0;
      newDist   = '0;
      PEready   = '0;
      CompStart = inCmp && strobeEn;
      VectorX   = '0;
      VectorY   = '0;
      AddressR  = '0;
      AddressS1 = '0;
      AddressS2 = '0;
      if (run) AddressR = lo;
      if (inBlk) begin
         S1S2mux   = {BLK{1'b1}} >> (XMAX - x);
         AddressS1 = {sumVY, 1'b0, x};
         AddressS2 = {sumVY, 1'b1, x};
         if (loHit && strobeEn) newDist = oneHot;
      end
      if (peHit) begin
         VectorX = lo[LB-1:0];
         VectorY = vyFull[LB-1:0];
         if (strobeEn) PEready = oneHot;
      end
   end

   assign busy = run;
   assign done = (state == FIN);

endmodule
